// File: rtl/button_conditioner_pkg.sv
// Shared constants and types for the pushbutton conditioner.
// Button indices follow the {s,r,l,d,u} bit order of btn_level.
package button_conditioner_pkg;

    localparam int NUM_BTNS = 5;

    localparam int BTN_U = 0;
    localparam int BTN_D = 1;
    localparam int BTN_L = 2;
    localparam int BTN_R = 3;
    localparam int BTN_S = 4;

    typedef enum logic [1:0] {
        R_IDLE,
        R_DELAY,
        R_REPEAT
    } rpt_state_t;

endpackage

// File: rtl/button_conditioner_channel.sv
// One button: 2-FF synchronizer, debounce filter, press-edge pulse
// and optional auto-repeat. Ports: clk, rst, btn (raw), pulse, level.
module button_channel
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES     = 1_000_000,
    parameter int REPEAT_DELAY_CYCLES = 50_000_000,
    parameter int REPEAT_RATE_CYCLES  = 10_000_000,
    parameter bit RPT_EN              = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse,
    output logic level
);

    localparam int DBW = (DEBOUNCE_CYCLES > 1) ?
                         $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int DLW = (REPEAT_DELAY_CYCLES > 1) ?
                         $clog2(REPEAT_DELAY_CYCLES) : 1;
    localparam int RTW = (REPEAT_RATE_CYCLES > 1) ?
                         $clog2(REPEAT_RATE_CYCLES) : 1;
    localparam int RW  = (DLW > RTW) ? DLW : RTW;

    localparam logic [DBW-1:0] DB_LAST  = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0]  DLY_LAST = RW'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [RW-1:0]  RATE_LAST = RW'(REPEAT_RATE_CYCLES - 1);

    logic           sync1;
    logic           sync2;
    logic [DBW-1:0] db_cnt;
    logic [RW-1:0]  rc;
    rpt_state_t     state;

    logic accept;
    logic rise;
    logic lvl_next;

    // The press pulse is registered on the same edge that the new
    // stable level is accepted, so btn_level and pulse move together.
    always_comb begin
        accept   = (sync2 != level) && (db_cnt == DB_LAST);
        rise     = accept && sync2;
        lvl_next = accept ? sync2 : level;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            level  <= 1'b0;
            db_cnt <= '0;
            rc     <= '0;
            state  <= R_IDLE;
            pulse  <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;

            if (sync2 == level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                level  <= sync2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DBW'(1);
            end

            pulse <= 1'b0;

            // Release (level about to read 0) wins over repeat expiry.
            case (state)
                R_IDLE: begin
                    if (rise) begin
                        pulse <= 1'b1;
                        rc    <= '0;
                        state <= RPT_EN ? R_DELAY : R_IDLE;
                    end
                end
                R_DELAY: begin
                    if (!lvl_next) begin
                        rc    <= '0;
                        state <= R_IDLE;
                    end else if (rc == DLY_LAST) begin
                        pulse <= 1'b1;
                        rc    <= '0;
                        state <= R_REPEAT;
                    end else begin
                        rc <= rc + RW'(1);
                    end
                end
                R_REPEAT: begin
                    if (!lvl_next) begin
                        rc    <= '0;
                        state <= R_IDLE;
                    end else if (rc == RATE_LAST) begin
                        pulse <= 1'b1;
                        rc    <= '0;
                    end else begin
                        rc <= rc + RW'(1);
                    end
                end
                default: begin
                    rc    <= '0;
                    state <= R_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Five-button conditioner: raw pushbuttons in, one-cycle commands out.
// Ports: clk, rst, btn_{u,d,l,r,s}, pulse_{u,d,l,r,s}, btn_level.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int             DEBOUNCE_CYCLES     = 1_000_000,
    parameter int             REPEAT_DELAY_CYCLES = 50_000_000,
    parameter int             REPEAT_RATE_CYCLES  = 10_000_000,
    parameter logic [NUM_BTNS-1:0] REPEAT_EN      = 5'b01111
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                btn_u,
    input  logic                btn_d,
    input  logic                btn_l,
    input  logic                btn_r,
    input  logic                btn_s,
    output logic                pulse_u,
    output logic                pulse_d,
    output logic                pulse_l,
    output logic                pulse_r,
    output logic                pulse_s,
    output logic [NUM_BTNS-1:0] btn_level
);

    logic [NUM_BTNS-1:0] raw;
    logic [NUM_BTNS-1:0] pulses;

    assign raw = {btn_s, btn_r, btn_l, btn_d, btn_u};

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_ch
        button_channel #(
            .DEBOUNCE_CYCLES     (DEBOUNCE_CYCLES),
            .REPEAT_DELAY_CYCLES (REPEAT_DELAY_CYCLES),
            .REPEAT_RATE_CYCLES  (REPEAT_RATE_CYCLES),
            .RPT_EN              (REPEAT_EN[i])
        ) u_ch (
            .clk   (clk),
            .rst   (rst),
            .btn   (raw[i]),
            .pulse (pulses[i]),
            .level (btn_level[i])
        );
    end

    assign pulse_u = pulses[BTN_U];
    assign pulse_d = pulses[BTN_D];
    assign pulse_l = pulses[BTN_L];
    assign pulse_r = pulses[BTN_R];
    assign pulse_s = pulses[BTN_S];

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Converts the five raw board pushbuttons (up, down, left, right, select) into clean single-cycle command pulses for the game FSM.
- Each button gets a 2-FF synchronizer, a debounce filter and press-edge detection.
- Direction buttons also get a held-key auto-repeat.
- Sits between the board I/O pins and the game logic; its outputs drive the game logic's pulse inputs directly.

Parameters:
DEBOUNCE_CYCLES, 1_000_000, cycles the synchronized level must hold before it is accepted (10 ms at 100 MHz); must be >= 2
REPEAT_DELAY_CYCLES, 50_000_000, cycles from the first press pulse to the first repeat pulse
REPEAT_RATE_CYCLES, 10_000_000, cycles between subsequent repeat pulses
REPEAT_EN, 5'b01111, per-button auto-repeat enable; bit order {s,r,l,d,u}, bit0 = u

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
btn_u  input  1  raw up button, asynchronous, active-high
btn_d  input  1  raw down button
btn_l  input  1  raw left button
btn_r  input  1  raw right button
btn_s  input  1  raw select button
pulse_u  output  1  one-cycle up command
pulse_d  output  1  one-cycle down command
pulse_l  output  1  one-cycle left command
pulse_r  output  1  one-cycle right command
pulse_s  output  1  one-cycle select command
btn_level  output  5  debounced levels {s,r,l,d,u}

Behaviour:
- Reset (rst high at an edge) clears:
  - sync flops, debounced levels, debounce counters and repeat counters to 0
  - repeat state to R_IDLE
  - all pulse outputs and btn_level to 0
  - No pulse is emitted while rst is high.
- Synchronizer: two flops per button; only the second stage is used downstream.
- Debounce, per button, evaluated every edge:
  - If sync level == stable level: counter <= 0.
  - Else if counter == DEBOUNCE_CYCLES-1: stable <= sync level, counter <= 0.
  - Else: counter++.
  - Any mismatch-free cycle restarts the count (bounce rejection).
- Press latency: for a clean rising input, the pulse is high for exactly one cycle following the (DEBOUNCE_CYCLES+2)-th rising edge. Edge 1 is the first edge that samples the new raw level.
- btn_level changes on the same edge the pulse asserts.
- Release (stable 1->0) never produces a pulse.
- Repeat FSM per button, states R_IDLE / R_DELAY / R_REPEAT, with repeat counter rc:
  - R_IDLE, on stable 0->1: emit pulse; rc <= 0; go to R_DELAY if the button's REPEAT_EN bit is 1, else stay in R_IDLE.
  - R_DELAY: rc++. When rc == REPEAT_DELAY_CYCLES-1: emit pulse, rc <= 0, go to R_REPEAT.
  - R_REPEAT: rc++. When rc == REPEAT_RATE_CYCLES-1: emit pulse, rc <= 0.
  - Any state, stable level 0: go to R_IDLE, rc <= 0, no pulse that cycle. Release has priority over a coinciding repeat expiry.
- Pulses are registered outputs and are never more than one cycle wide.
  - A non-repeat button gives exactly one pulse per debounced press regardless of hold time.
  - A repeat button gives consecutive pulses at least min(REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES) cycles apart.
- Buttons are fully independent. Simultaneous presses produce simultaneous pulses; there is no arbitration or priority.
- Counter widths are $clog2 of the respective parameter; counters never wrap because they are cleared at the terminal value.
- Reset mid-operation: state is lost. A button still held when rst falls is treated as a new press, so it pulses DEBOUNCE_CYCLES+2 edges after rst deasserts.

Decomposition:
- Shared package (alongside the game states package):
  - constants NUM_BTNS = 5 and BTN_U=0, BTN_D=1, BTN_L=2, BTN_R=3, BTN_S=4
  - typedef enum logic [1:0] rpt_state_t {R_IDLE, R_DELAY, R_REPEAT}
- Sub-module button_channel: one button's sync, debounce and repeat logic, with parameters DEBOUNCE_CYCLES, REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES and RPT_EN (1 bit).
- The top instantiates five channels via generate and maps them onto the named ports.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY_CYCLES=20, REPEAT_RATE_CYCLES=8):
1. btn_l clean rise, held 15 cycles -> pulse_l high for exactly 1 cycle after edge 6, btn_level[2]=1 from edge 6; nothing else pulses.
2. btn_r toggles every 2 cycles for 12 cycles, then holds high -> exactly one pulse_r, 6 edges after the final rising transition; no pulse during bouncing.
3. btn_d held 60 cycles after its first pulse at edge E -> pulse_d at E, E+20, E+28, E+36, E+44, E+52; release -> no further pulses and no release pulse.
4. btn_s held 60 cycles -> exactly one pulse_s (REPEAT_EN bit4=0).
5. btn_u and btn_l rise on the same cycle -> pulse_u and pulse_l asserted on the same cycle; btn_level=5'b00101.
6. btn_d held, rst asserted 3 cycles in R_DELAY -> all outputs 0 from the first reset edge, no pulses during reset; new pulse_d 6 edges after rst deasserts.
